// File: rtl/sym_strobe_gen_pkg.sv
// Shared definitions for the sym_strobe_gen strobe generator.
// Optional slip counter is enabled by defining SYM_STROBE_GEN_SLIP_CNT_EN.
package sym_strobe_gen_pkg;

  localparam int SAMP_DIV_DEF = 4;
  localparam int UPS_DEF      = 4;
  localparam int SLIP_CNT_W   = 8;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int pw_of(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sym_strobe_gen_if.sv
// Control/strobe bundle between sym_strobe_gen and its consumers.
// slip/slip_cnt exist only when SYM_STROBE_GEN_SLIP_CNT_EN is defined.
interface sym_strobe_gen_if #(
  parameter int PW = 4,
  parameter int IW = 2
);
  logic          run;
  logic          sync;
  logic [PW-1:0] phase;
  logic [IW-1:0] samp_idx;
  logic          samp_en;
  logic          sym_en;
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
  logic          slip;
  logic [7:0]    slip_cnt;
`endif

  modport master (
    input  run, sync,
    output phase, samp_idx, samp_en, sym_en
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    , output slip, slip_cnt
`endif
  );

  modport slave (
    output run, sync,
    input  phase, samp_idx, samp_en, sym_en
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    , input slip, slip_cnt
`endif
  );
endinterface

// File: rtl/sym_strobe_gen_mod_cnt.sv
// Modulo-N counter with enable, synchronous clear-to-zero and wrap flag.
module mod_cnt
  import sym_strobe_gen_pkg::*;
#(
  parameter int N = 4,
  localparam int W = pw_of(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic [W-1:0] nxt,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  always_comb begin
    wrap = en && !clr && (cnt == LAST);
    nxt  = cnt;
    if (clr)
      nxt = '0;
    else if (en)
      nxt = (cnt == LAST) ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else
      cnt <= nxt;
  end

endmodule

// File: rtl/sym_strobe_gen.sv
// Sample/symbol enable strobe generator with run gating, strobe offset and sync.
// Define SYM_STROBE_GEN_SLIP_CNT_EN to add the slip pulse and saturating slip_cnt.
module sym_strobe_gen
  import sym_strobe_gen_pkg::*;
#(
  parameter int SAMP_DIV = SAMP_DIV_DEF,
  parameter int UPS      = UPS_DEF,
  parameter int STRB_OFS = 0,
  localparam int TOTAL   = SAMP_DIV * UPS,
  localparam int PW      = pw_of(TOTAL),
  localparam int IW      = pw_of(UPS),
  localparam int SW      = pw_of(SAMP_DIV)
) (
  input logic              clk,
  input logic              reset_n,
  sym_strobe_gen_if.master bus
);

  localparam logic [SW-1:0] OFS_W   = SW'(STRB_OFS);
  localparam logic [PW-1:0] SD_W    = PW'(SAMP_DIV);
  localparam logic [PW-1:0] LAST_PH = PW'(TOTAL - 1);

  logic [SW-1:0] cnt_s, nxt_s;
  logic [IW-1:0] cnt_i, nxt_i;
  logic          wrap_s;
  logic          idx_wrap_unused;
  logic          adv;
  logic          strb_hit;

  mod_cnt #(.N(SAMP_DIV)) u_samp_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (bus.run),
    .clr     (bus.sync),
    .cnt     (cnt_s),
    .nxt     (nxt_s),
    .wrap    (wrap_s)
  );

  mod_cnt #(.N(UPS)) u_idx_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (wrap_s),
    .clr     (bus.sync),
    .cnt     (cnt_i),
    .nxt     (nxt_i),
    .wrap    (idx_wrap_unused)
  );

  // Strobes only accompany a phase that was freshly entered, never a held one.
  assign adv      = bus.run | bus.sync;
  assign strb_hit = adv && (nxt_s == OFS_W);

  assign bus.samp_idx = cnt_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.phase   <= '0;
      bus.samp_en <= 1'b0;
      bus.sym_en  <= 1'b0;
    end else begin
      bus.phase   <= PW'(nxt_i) * SD_W + PW'(nxt_s);
      bus.samp_en <= strb_hit;
      bus.sym_en  <= strb_hit && (nxt_i == '0);
    end
  end

`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
  logic natural_zero;

  // A sync is harmless when the phase would have landed on 0 anyway.
  assign natural_zero = (bus.run && (bus.phase == LAST_PH)) ||
                        (!bus.run && (bus.phase == '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.slip     <= 1'b0;
      bus.slip_cnt <= '0;
    end else begin
      bus.slip <= bus.sync && !natural_zero;
      if (bus.sync && !natural_zero && (bus.slip_cnt != 8'hFF))
        bus.slip_cnt <= bus.slip_cnt + 8'd1;
    end
  end
`else
  logic last_ph_unused;
  assign last_ph_unused = ^LAST_PH;
`endif

endmodule

// File: tb/tb_sym_strobe_gen.sv
// Self-checking bench for sym_strobe_gen: default build and SAMP_DIV=2/UPS=8/STRB_OFS=1.
// Slip checks activate when SYM_STROBE_GEN_SLIP_CNT_EN is defined.
module tb_sym_strobe_gen;
  import sym_strobe_gen_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0;
  logic sync = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  sym_strobe_gen_if #(.PW(4), .IW(2)) if0 ();
  sym_strobe_gen_if #(.PW(4), .IW(3)) if1 ();

  assign if0.run  = run;
  assign if0.sync = sync;
  assign if1.run  = run;
  assign if1.sync = sync;

  sym_strobe_gen u_dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
  sym_strobe_gen #(.SAMP_DIV(2), .UPS(8), .STRB_OFS(1)) u_dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));

  function automatic int sd_of(input int d);  return (d == 0) ? 4 : 2; endfunction
  function automatic int tot_of(input int d); return 16; endfunction
  function automatic int ofs_of(input int d); return (d == 0) ? 0 : 1; endfunction

  // Reference model: phase as an integer plus "freshly entered" flag.
  int m_ph[2];
  bit m_ent[2];
  bit m_slip[2];
  int m_scnt[2];

  always @(posedge clk or negedge reset_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n) begin
        m_ph[d] = 0; m_ent[d] = 0; m_slip[d] = 0; m_scnt[d] = 0;
      end else begin
        int old;
        old = m_ph[d];
        m_slip[d] = 0;
        if (sync) begin
          m_slip[d] = !((run && old == tot_of(d) - 1) || (!run && old == 0));
          m_ph[d] = 0;
          m_ent[d] = 1;
        end else if (run) begin
          m_ph[d] = (old + 1) % tot_of(d);
          m_ent[d] = 1;
        end else begin
          m_ent[d] = 0;
        end
        if (m_slip[d] && m_scnt[d] < 255) m_scnt[d]++;
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input int d, input int ph, input int idx, input int se, input int ye,
                           input int sl, input int sc);
    int e_se, e_ye;
    e_se = (m_ent[d] && (m_ph[d] % sd_of(d)) == ofs_of(d)) ? 1 : 0;
    e_ye = (m_ent[d] && m_ph[d] == ofs_of(d)) ? 1 : 0;
    chk($sformatf("m%0d.phase", d), ph, m_ph[d]);
    chk($sformatf("m%0d.samp_idx", d), idx, m_ph[d] / sd_of(d));
    chk($sformatf("m%0d.samp_en", d), se, e_se);
    chk($sformatf("m%0d.sym_en", d), ye, e_ye);
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    chk($sformatf("m%0d.slip", d), sl, int'(m_slip[d]));
    chk($sformatf("m%0d.slip_cnt", d), sc, m_scnt[d]);
`else
    if (sl != 0 || sc != 0) chk("unused_slip", sl + sc, 0);
`endif
  endtask

  always @(negedge clk) begin
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    cmp_model(0, int'(if0.phase), int'(if0.samp_idx), int'(if0.samp_en), int'(if0.sym_en),
              int'(if0.slip), int'(if0.slip_cnt));
    cmp_model(1, int'(if1.phase), int'(if1.samp_idx), int'(if1.samp_en), int'(if1.sym_en),
              int'(if1.slip), int'(if1.slip_cnt));
`else
    cmp_model(0, int'(if0.phase), int'(if0.samp_idx), int'(if0.samp_en), int'(if0.sym_en), 0, 0);
    cmp_model(1, int'(if1.phase), int'(if1.samp_idx), int'(if1.samp_en), int'(if1.sym_en), 0, 0);
`endif
  end

  task automatic wait_phase0(input int target);
    int n;
    n = 0;
    @(negedge clk);
    while (int'(if0.phase) != target && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk($sformatf("timeout_phase_%0d", target), int'(if0.phase), target);
  endtask

  task automatic check_release_seq(input int edges);
    for (int k = 1; k <= edges; k++) begin
      @(negedge clk);
      chk("s1.phase0", int'(if0.phase), k % 16);
      chk("s1.samp_en0", int'(if0.samp_en), (k % 4 == 0) ? 1 : 0);
      chk("s1.sym_en0", int'(if0.sym_en), (k % 16 == 0) ? 1 : 0);
      chk("s1.samp_idx0", int'(if0.samp_idx), (k % 16) / 4);
      chk("s1.samp_en1", int'(if1.samp_en), (k % 2 == 1) ? 1 : 0);
      chk("s1.sym_en1", int'(if1.sym_en), (k % 16 == 1) ? 1 : 0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst.phase", int'(if0.phase), 0);
    chk("rst.samp_en", int'(if0.samp_en), 0);
    chk("rst.sym_en", int'(if0.sym_en), 0);
    #1 run = 1'b1; reset_n = 1'b1;
    check_release_seq(20);

    // run dropped for three clocks at phase 5
    wait_phase0(5);
    #1 run = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold.phase", int'(if0.phase), 5);
      chk("hold.samp_en", int'(if0.samp_en), 0);
    end
    #1 run = 1'b1;
    @(negedge clk);
    chk("hold.resume", int'(if0.phase), 6);

    // misaligned sync at phase 9
    wait_phase0(9);
    #1 sync = 1'b1;
    @(negedge clk);
    chk("sync9.phase", int'(if0.phase), 0);
    chk("sync9.samp_idx", int'(if0.samp_idx), 0);
    chk("sync9.samp_en", int'(if0.samp_en), 1);
    chk("sync9.sym_en", int'(if0.sym_en), 1);
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    chk("sync9.slip", int'(if0.slip), 1);
    chk("sync9.slip_cnt", int'(if0.slip_cnt), 1);
`endif
    #1 sync = 1'b0;

    // aligned sync at phase 15
    wait_phase0(15);
    #1 sync = 1'b1;
    @(negedge clk);
    chk("sync15.phase", int'(if0.phase), 0);
    chk("sync15.sym_en", int'(if0.sym_en), 1);
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    chk("sync15.slip", int'(if0.slip), 0);
    chk("sync15.slip_cnt", int'(if0.slip_cnt), 1);
`endif
    #1 sync = 1'b0;

    // asynchronous reset between edges at phase 7
    wait_phase0(7);
    #1 reset_n = 1'b0;
    #1;
    chk("arst.phase", int'(if0.phase), 0);
    chk("arst.samp_idx", int'(if0.samp_idx), 0);
    chk("arst.samp_en", int'(if0.samp_en), 0);
    chk("arst.phase1", int'(if1.phase), 0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    check_release_seq(16);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #1;
      run  = ($urandom_range(0, 99) < 80);
      sync = ($urandom_range(0, 99) < 5);
      reset_n = ($urandom_range(0, 999) >= 5);
    end
    @(negedge clk);
    #1 reset_n = 1'b1; run = 1'b1; sync = 1'b0;

    // repeated misaligned syncs drive the slip counter to saturation
    @(negedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b1; sync = 1'b1;
    repeat (300) @(negedge clk);
`ifdef SYM_STROBE_GEN_SLIP_CNT_EN
    chk("sat.slip_cnt1", int'(if1.slip_cnt), 255);
`endif
    chk("sat.phase1", int'(if1.phase), 0);
    chk("sat.samp_en1", int'(if1.samp_en), 0);
    chk("sat.sym_en0", int'(if0.sym_en), 1);
    #1 sync = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
